// File: rtl/phase_shift_gen.sv
`default_nettype none
// ============================================================================
// Module   : phase_shift_gen
// Brief    : Pair of square waves (period 2H) with out_b delayed P cycles from
//            out_a; double-buffered config applied at idle or at period wrap.
// Revision : 1.0 - initial release
// ============================================================================
module phase_shift_gen #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic [CNT_W-1:0] cfg_phase,
    output logic             cfg_err,
    output logic             out_a,
    output logic             out_b,
    output logic             lead,
    output logic             period_stb
);

    localparam logic [CNT_W:0] c_one = {{CNT_W{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W:0]   r_cnt;
    logic [CNT_W:0]   w_cnt_nxt;
    logic             r_out_a;
    logic             r_out_b;
    logic             r_stb;
    logic             w_out_a_nxt;
    logic             w_out_b_nxt;
    logic             w_stb_nxt;
    logic             w_load;

    logic [CNT_W-1:0] r_act_h;
    logic [CNT_W-1:0] r_act_p;
    logic [CNT_W-1:0] r_pend_h;
    logic [CNT_W-1:0] r_pend_p;
    logic             r_pend_v;
    logic             r_cfg_err;
    logic             r_lead;

    logic             w_accept;
    logic             w_cfg_ok;
    logic [CNT_W:0]   w_cfg_two_h;
    logic [CNT_W:0]   w_act_h_x;
    logic [CNT_W:0]   w_act_p_x;
    logic [CNT_W:0]   w_two_h;
    logic             w_last;
    logic [CNT_W:0]   w_pos;

    assign w_accept    = cfg_valid & ~r_pend_v;
    assign w_cfg_two_h = {cfg_half, 1'b0};
    // Top bit of H set means 2H does not fit in CNT_W bits.
    assign w_cfg_ok    = (cfg_half != '0) && !cfg_half[CNT_W-1]
                         && ({1'b0, cfg_phase} < w_cfg_two_h);

    assign w_act_h_x = {1'b0, r_act_h};
    assign w_act_p_x = {1'b0, r_act_p};
    assign w_two_h   = {r_act_h, 1'b0};
    assign w_last    = (r_cnt == (w_two_h - c_one));
    // Position of cnt within out_b's own period, i.e. (cnt - P) mod 2H.
    assign w_pos     = (r_cnt >= w_act_p_x) ? (r_cnt - w_act_p_x)
                                            : (r_cnt + w_two_h - w_act_p_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_out_a <= 1'b0;
            r_out_b <= 1'b0;
            r_stb   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out_a <= w_out_a_nxt;
            r_out_b <= w_out_b_nxt;
            r_stb   <= w_stb_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_out_a_nxt = 1'b0;
        w_out_b_nxt = 1'b0;
        w_stb_nxt   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load = r_pend_v;
                if (en && (r_act_h != '0)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_out_a_nxt = (r_cnt < w_act_h_x);
                    w_out_b_nxt = (w_pos < w_act_h_x);
                    if (w_last) begin
                        w_stb_nxt = 1'b1;
                        w_load    = r_pend_v;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A load and an accept can never coincide: load needs pend_v=1, accept needs 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_h   <= '0;
            r_act_p   <= '0;
            r_pend_h  <= '0;
            r_pend_p  <= '0;
            r_pend_v  <= 1'b0;
            r_cfg_err <= 1'b0;
            r_lead    <= 1'b0;
        end else begin
            r_cfg_err <= w_accept & ~w_cfg_ok;
            if (w_load) begin
                r_act_h  <= r_pend_h;
                r_act_p  <= r_pend_p;
                r_lead   <= (r_pend_p < r_pend_h);
                r_pend_v <= 1'b0;
            end else if (w_accept && w_cfg_ok) begin
                r_pend_h <= cfg_half;
                r_pend_p <= cfg_phase;
                r_pend_v <= 1'b1;
            end
        end
    end

    assign cfg_ready  = ~r_pend_v;
    assign cfg_err    = r_cfg_err;
    assign out_a      = r_out_a;
    assign out_b      = r_out_b;
    assign lead       = r_lead;
    assign period_stb = r_stb;

endmodule
`default_nettype wire

// File: tb/tb_phase_shift_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_shift_gen
// Brief    : Directed + random bench for phase_shift_gen against a modular-
//            arithmetic reference of the two waveforms.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_shift_gen;

    localparam int CNT_W = 24;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic [CNT_W-1:0] cfg_phase = '0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             out_a;
    logic             out_b;
    logic             lead;
    logic             period_stb;

    int n_assert = 0;
    int n_fail   = 0;

    phase_shift_gen #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_half   (cfg_half),
        .cfg_phase  (cfg_phase),
        .cfg_err    (cfg_err),
        .out_a      (out_a),
        .out_b      (out_b),
        .lead       (lead),
        .period_stb (period_stb)
    );

    always #5 clk = ~clk;

    // Reference: running flag, phase k within [0,2H), expected registered outputs.
    bit     m_run = 1'b0;
    bit     m_pv = 1'b0;
    longint m_k = 0, m_h = 0, m_p = 0, m_ph = 0, m_pp = 0;
    bit     e_a = 1'b0, e_b = 1'b0, e_stb = 1'b0, e_err = 1'b0, e_lead = 1'b0;

    function automatic bit cfg_good(longint h, longint p);
        return (h != 0) && (2 * h < (longint'(1) << CNT_W)) && (p < 2 * h);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit acc, go, ok;
        if (!rst_n) begin
            m_run = 0; m_pv = 0; m_k = 0; m_h = 0; m_p = 0; m_ph = 0; m_pp = 0;
            e_a = 0; e_b = 0; e_stb = 0; e_err = 0; e_lead = 0;
        end else begin
            acc   = cfg_valid && !m_pv;
            ok    = cfg_good(longint'(cfg_half), longint'(cfg_phase));
            e_err = acc && !ok;
            if (!m_run) begin
                e_a = 0; e_b = 0; e_stb = 0;
                go  = en && (m_h != 0);
                if (m_pv) begin
                    m_h = m_ph; m_p = m_pp; e_lead = (m_pp < m_ph); m_pv = 0;
                end
                if (go) begin
                    m_run = 1; m_k = 0;
                end
            end else if (!en) begin
                m_run = 0; m_k = 0; e_a = 0; e_b = 0; e_stb = 0;
            end else begin
                e_a = (m_k < m_h);
                e_b = (((m_k - m_p + 2 * m_h) % (2 * m_h)) < m_h);
                if (m_k == 2 * m_h - 1) begin
                    m_k = 0; e_stb = 1;
                    if (m_pv) begin
                        m_h = m_ph; m_p = m_pp; e_lead = (m_pp < m_ph); m_pv = 0;
                    end
                end else begin
                    m_k++; e_stb = 0;
                end
            end
            if (acc && ok) begin
                m_pv = 1; m_ph = longint'(cfg_half); m_pp = longint'(cfg_phase);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_a", 64'(out_a), 64'(e_a));
        chk("out_b", 64'(out_b), 64'(e_b));
        chk("period_stb", 64'(period_stb), 64'(e_stb));
        chk("cfg_err", 64'(cfg_err), 64'(e_err));
        chk("lead", 64'(lead), 64'(e_lead));
        chk("cfg_ready", 64'(cfg_ready), 64'(!m_pv));
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic offer(input int h, input int p);
        cfg_half  = CNT_W'(h);
        cfg_phase = CNT_W'(p);
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_stb();
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            cyc();
            seen = period_stb;
        end
        if (!seen) chk("stb_timeout", 64'(0), 64'(1));
    endtask

    task automatic collect(input int n, output logic [7:0] pa, output logic [7:0] pb,
                           output int ns);
        pa = '0; pb = '0; ns = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            pa = {pa[6:0], out_a};
            pb = {pb[6:0], out_b};
            ns += int'(period_stb);
        end
    endtask

    initial begin
        logic [7:0] pa, pb, px;
        int         ns;
        int         h, p, r;

        // Reset state
        cyc(2);
        chk("rst_ready", 64'(cfg_ready), 64'(1));
        chk("rst_out_a", 64'(out_a), 64'(0));
        rst_n = 1'b1;

        // en alone without config must stay idle
        en = 1'b1;
        cyc(4);
        chk("noconf_out_a", 64'(out_a), 64'(0));

        // H=4, P=2
        offer(4, 2);
        wait_stb();
        collect(8, pa, pb, ns);
        chk("h4p2_a", 64'(pa), 64'(8'hF0));
        chk("h4p2_b", 64'(pb), 64'(8'h3C));
        chk("h4p2_lead", 64'(lead), 64'(1));
        chk("h4p2_stb_count", 64'(ns), 64'(1));
        chk("h4p2_stb_last", 64'(period_stb), 64'(1));

        // Rejections: P>=2H, H=0, 2H overflow
        offer(4, 8);
        chk("err_p8", 64'(cfg_err), 64'(1));
        cyc();
        chk("err_p8_once", 64'(cfg_err), 64'(0));
        offer(0, 0);
        chk("err_h0", 64'(cfg_err), 64'(1));
        cyc();
        chk("err_h0_once", 64'(cfg_err), 64'(0));
        offer(1 << (CNT_W - 1), 0);
        chk("err_ovf", 64'(cfg_err), 64'(1));
        wait_stb();
        collect(8, pa, pb, ns);
        chk("after_err_a", 64'(pa), 64'(8'hF0));
        chk("after_err_b", 64'(pb), 64'(8'h3C));
        chk("after_err_lead", 64'(lead), 64'(1));

        // H=4, P=6 (lag)
        offer(4, 6);
        wait_stb();
        collect(8, pa, pb, ns);
        px = pa ^ pb;
        chk("h4p6_a", 64'(pa), 64'(8'hF0));
        chk("h4p6_b", 64'(pb), 64'(8'hC3));
        chk("h4p6_lead", 64'(lead), 64'(0));
        chk("h4p6_xor_hi", 64'($countones(px[7:4])), 64'(2));
        chk("h4p6_xor_lo", 64'($countones(px[3:0])), 64'(2));

        // Back to H=4,P=2 then switch mid-period to H=2,P=1
        offer(4, 2);
        wait_stb();
        collect(8, pa, pb, ns);
        cyc(3);
        offer(2, 1);
        chk("pend_ready_low", 64'(cfg_ready), 64'(0));
        cfg_half = CNT_W'(3); cfg_phase = CNT_W'(1); cfg_valid = 1'b1;
        cyc(2);
        chk("second_offer_ready", 64'(cfg_ready), 64'(0));
        cfg_valid = 1'b0;
        wait_stb();
        chk("ready_back", 64'(cfg_ready), 64'(1));
        collect(4, pa, pb, ns);
        chk("h2p1_a", 64'(pa[3:0]), 64'(4'hC));
        chk("h2p1_b", 64'(pb[3:0]), 64'(4'h6));
        collect(4, pa, pb, ns);
        chk("h2p1_a2", 64'(pa[3:0]), 64'(4'hC));
        chk("h2p1_stb", 64'(ns), 64'(1));

        // en drop mid-period, restart from cnt=0
        cyc(1);
        en = 1'b0;
        cyc(1);
        chk("endrop_a", 64'(out_a), 64'(0));
        chk("endrop_b", 64'(out_b), 64'(0));
        cyc(2);
        en = 1'b1;
        cyc(1);
        collect(4, pa, pb, ns);
        chk("restart_a", 64'(pa[3:0]), 64'(4'hC));
        chk("restart_b", 64'(pb[3:0]), 64'(4'h6));

        // Async reset mid-run
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a", 64'(out_a), 64'(0));
        chk("arst_b", 64'(out_b), 64'(0));
        chk("arst_stb", 64'(period_stb), 64'(0));
        chk("arst_lead", 64'(lead), 64'(0));
        chk("arst_ready", 64'(cfg_ready), 64'(1));
        cyc(1);
        rst_n = 1'b1;
        cyc(6);
        chk("arst_idle_a", 64'(out_a), 64'(0));

        // Random traffic against the reference
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5) en = ~en;
            else if (r < 8) en = 1'b1;
            if (r >= 80) begin
                h = int'($urandom_range(1, 6));
                p = int'($urandom_range(0, 2 * h - 1));
                if (r >= 96) p = 2 * h + int'($urandom_range(0, 2));
                if (r == 99) h = 0;
                cfg_half = CNT_W'(h); cfg_phase = CNT_W'(p); cfg_valid = 1'b1;
            end else begin
                cfg_valid = 1'b0;
            end
            cyc(1);
        end
        cfg_valid = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
